// File: rtl/am_lock_supervisor.sv
// Link-level sequencer for the AM lock lanes: enables the lanes, waits for block
// lock and AM lock, checks lane IDs form a permutation, then releases deskew.
module am_lock_supervisor #(
  parameter int N_LANES            = 20,
  parameter int NB_LANE_ID         = 5,
  parameter int NB_TIMER           = 24,
  parameter int NB_RESTART_COUNTER = 8,
  parameter int RESET_CYCLES       = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_rf_enable,
  input  logic                          i_valid,
  input  logic [N_LANES-1:0]            i_block_lock,
  input  logic [N_LANES-1:0]            i_am_lock,
  input  logic [N_LANES-1:0]            i_resync,
  input  logic [N_LANES*NB_LANE_ID-1:0] i_lane_id,
  input  logic [NB_TIMER-1:0]           i_rf_lock_timeout,
  output logic [N_LANES-1:0]            o_lane_enable,
  output logic                          o_lane_soft_reset,
  output logic                          o_deskew_enable,
  output logic                          o_align_status,
  output logic [N_LANES-1:0]            o_missing_ids,
  output logic [NB_RESTART_COUNTER-1:0] o_restart_counter,
  output logic [2:0]                    o_state
);

  localparam int NB_RST_CNT = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BLOCK = 3'd1,
    WAIT_AM    = 3'd2,
    CHECK_ID   = 3'd3,
    ALIGNED    = 3'd4,
    RESTART    = 3'd5
  } state_t;

  state_t                          state_reg, state_next;
  logic [NB_TIMER-1:0]             timer_reg, timer_next;
  logic [NB_RST_CNT-1:0]           rst_cnt_reg, rst_cnt_next;
  logic [N_LANES-1:0]              missing_ids_reg, missing_ids_next;
  logic [NB_RESTART_COUNTER-1:0]   restart_cnt_reg, restart_cnt_next;
  logic [N_LANES-1:0]              coverage;
  logic [NB_TIMER-1:0]             timer_inc;
  logic                            timeout_hit;

  // match[i][k]: physical lane k reports logical ID i. IDs >= N_LANES match nothing.
  logic [N_LANES-1:0] match [N_LANES];

  genvar gi, gk;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_id
      for (gk = 0; gk < N_LANES; gk++) begin : g_lane
        assign match[gi][gk] = (i_lane_id[gk*NB_LANE_ID +: NB_LANE_ID] == NB_LANE_ID'(gi));
      end
      assign coverage[gi] = |match[gi];
    end
  endgenerate

  assign timer_inc   = (timer_reg == '1) ? timer_reg : timer_reg + NB_TIMER'(1);
  assign timeout_hit = (i_rf_lock_timeout != '0) && i_valid &&
                       (timer_reg == i_rf_lock_timeout - NB_TIMER'(1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      rst_cnt_reg     <= '0;
      missing_ids_reg <= '0;
      restart_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      rst_cnt_reg     <= rst_cnt_next;
      missing_ids_reg <= missing_ids_next;
      restart_cnt_reg <= restart_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    rst_cnt_next     = rst_cnt_reg;
    missing_ids_next = missing_ids_reg;
    restart_cnt_next = restart_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (i_rf_enable) begin
          state_next = WAIT_BLOCK;
          timer_next = '0;
        end
      end
      WAIT_BLOCK: begin
        if (i_valid) timer_next = timer_inc;
        // A lock seen in the timeout cycle takes precedence.
        if (&i_block_lock) begin
          state_next = WAIT_AM;
          timer_next = '0;
        end else if (timeout_hit) begin
          state_next = RESTART;
        end
      end
      WAIT_AM: begin
        if (i_valid) timer_next = timer_inc;
        if (!(&i_block_lock))   state_next = RESTART;
        else if (&i_am_lock)    state_next = CHECK_ID;
        else if (timeout_hit)   state_next = RESTART;
      end
      CHECK_ID: begin
        // With N_LANES lanes, full coverage implies no duplicates and no out-of-range IDs.
        missing_ids_next = ~coverage;
        state_next       = (&coverage) ? ALIGNED : RESTART;
      end
      ALIGNED: begin
        if (!(&i_block_lock) || !(&i_am_lock) || (|i_resync)) state_next = RESTART;
      end
      RESTART: begin
        if (rst_cnt_reg == NB_RST_CNT'(RESET_CYCLES - 1)) begin
          state_next = WAIT_BLOCK;
          timer_next = '0;
        end else begin
          rst_cnt_next = rst_cnt_reg + NB_RST_CNT'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (!i_rf_enable) begin
      state_next       = IDLE;
      timer_next       = '0;
      rst_cnt_next     = '0;
      missing_ids_next = missing_ids_reg;
    end

    if (state_next == RESTART && state_reg != RESTART) begin
      rst_cnt_next = '0;
      timer_next   = '0;
      if (restart_cnt_reg != '1) restart_cnt_next = restart_cnt_reg + NB_RESTART_COUNTER'(1);
    end
  end

  always_comb begin
    o_lane_enable     = '0;
    o_lane_soft_reset = 1'b0;
    o_deskew_enable   = 1'b0;
    o_align_status    = 1'b0;
    case (state_reg)
      WAIT_BLOCK, WAIT_AM, CHECK_ID: o_lane_enable = '1;
      ALIGNED: begin
        o_lane_enable   = '1;
        o_deskew_enable = 1'b1;
        o_align_status  = 1'b1;
      end
      RESTART: o_lane_soft_reset = 1'b1;
      default: ;
    endcase
  end

  assign o_missing_ids     = missing_ids_reg;
  assign o_restart_counter = restart_cnt_reg;
  assign o_state           = state_reg;

endmodule
